delay_tap_reader: RTL and testbench

//  Read side of the pedal sample memory: once per audio sample, fetches up to MAX_TAPS

---
 rtl/pedal_mem_pkg.sv | 31 +++
 rtl/delay_tap_reader_if.sv | 14 +
 rtl/delay_tap_reader_tap_mac.sv | 24 ++
 rtl/delay_tap_reader.sv | 196 +++++++++++++++++++
 tb/tb_delay_tap_reader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pedal_mem_pkg.sv
// pedal_mem_pkg: shared definitions for the pedal sample memory (reader and
// memory controller): FSM state encodings, sample limits and the Q1.15 helpers.
package pedal_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } tap_state_t;

  // Q1.15: 0x7FFF is the largest representable gain, just below 1.0
  localparam logic [15:0] Q15_ONE    = 16'h7FFF;
  localparam int          Q_FRAC     = 15;
  localparam int          SAMPLE_MAX = int'(Q15_ONE);
  localparam int          SAMPLE_MIN = -32768;

  // Clamp a wide signed value into the 16-bit sample range
  function automatic logic [15:0] sat16(input logic signed [31:0] value);
    logic [15:0] res;
    if (value > SAMPLE_MAX) begin
      res = 16'h7FFF;
    end else if (value < SAMPLE_MIN) begin
      res = 16'h8000;
    end else begin
      res = value[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_tap_reader_if.sv
// delay_tap_reader_if: read port of the pedal sample memory.
// master = tap reader (issues requests), slave = memory controller.
interface delay_tap_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_re, mem_addr, input mem_ready, mem_rdata);
  modport slave  (input mem_re, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/delay_tap_reader_tap_mac.sv
// tap_mac: signed DATA_W x DATA_W multiply, Q1.15 rescale (arithmetic shift)
// and add to a wide accumulator. The reader time-shares one instance between
// the weight update (addend = 0) and the tap accumulate.
module tap_mac
  import pedal_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 21
) (
  input  logic signed [DATA_W-1:0] mul_a,
  input  logic signed [DATA_W-1:0] mul_b,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  result
);
  logic signed [2*DATA_W-1:0] product;
  logic signed [2*DATA_W-1:0] scaled;

  // Rescaled product fits in DATA_W+1 bits, so truncating to ACC_W is lossless
  always_comb begin
    product = mul_a * mul_b;
    scaled  = product >>> Q_FRAC;
    result  = addend + ACC_W'(scaled);
  end
endmodule

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: once per adc_clock tick, reads up to MAX_TAPS delayed
// samples behind the write pointer, weights tap k by gain^k (Q1.15) and mixes
// them with the dry sample. Optional read timeout: DELAY_TAP_READER_TIMEOUT_EN.
module delay_tap_reader
  import pedal_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_TAPS = 8
`ifdef DELAY_TAP_READER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_clock,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       delay_reverb,
  input  logic [15:0]       gain,
  input  logic [15:0]       impulses,
  input  logic [DATA_W-1:0] data_in,
  delay_tap_reader_if.master mem,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun,
  output logic              mem_err
);
  localparam int ACC_W = DATA_W + $clog2(MAX_TAPS) + 2;
  localparam int N_W   = $clog2(MAX_TAPS + 1);

  tap_state_t               state;
  logic [2:0]               adc_sync;
  logic                     tick;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  mac_add;
  logic signed [ACC_W-1:0]  mac_res;
  logic signed [DATA_W-1:0] w;
  logic signed [DATA_W-1:0] w_upd;
  logic signed [DATA_W-1:0] gain_s;
  logic signed [DATA_W-1:0] rdata;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic [ADDR_W-1:0]        delay_s;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        first_addr;
  logic [N_W-1:0]           n_taps;
  logic [N_W-1:0]           n_clamp;
  logic [N_W-1:0]           k;
  logic                     rd_req;
`ifdef DELAY_TAP_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]          wait_cnt;
`endif

  assign mem.mem_re   = rd_req;
  assign mem.mem_addr = rd_addr;
  assign tick         = adc_sync[1] & ~adc_sync[2];

  // Bring the asynchronous sample clock in through two flops plus an edge flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_sync <= '0;
    end else begin
      adc_sync <= {adc_sync[1:0], adc_clock};
    end
  end

  // Tap count clamp and first read address, evaluated on the live inputs at the tick
  always_comb begin
    n_clamp    = (impulses > 16'(MAX_TAPS)) ? N_W'(MAX_TAPS) : N_W'(impulses);
    first_addr = wr_addr - ADDR_W'(delay_reverb);
  end

  // Share one multiplier: REQ computes the next weight, MAC accumulates the tap
  always_comb begin
    mac_a   = w;
    mac_b   = gain_s;
    mac_add = '0;
    if (state == ST_MAC) begin
      mac_a   = rdata;
      mac_b   = w;
      mac_add = acc;
    end
  end

  tap_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_tap_mac (
    .mul_a  (mac_a),
    .mul_b  (mac_b),
    .addend (mac_add),
    .result (mac_res)
  );

  // Sample sequencer: IDLE -> REQ -> MAC -> (REQ | OUT) -> IDLE, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      w          <= '0;
      w_upd      <= '0;
      gain_s     <= '0;
      rdata      <= '0;
      delay_s    <= '0;
      rd_addr    <= '0;
      n_taps     <= '0;
      k          <= '0;
      rd_req     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef DELAY_TAP_READER_TIMEOUT_EN
      mem_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (tick && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            acc     <= ACC_W'($signed(data_in));
            w       <= DATA_W'(gain);
            gain_s  <= DATA_W'(gain);
            delay_s <= ADDR_W'(delay_reverb);
            n_taps  <= n_clamp;
            k       <= '0;
            busy    <= 1'b1;
            if (!enable || n_clamp == '0) begin
              state <= ST_OUT;
            end else begin
              state   <= ST_REQ;
              rd_req  <= 1'b1;
              rd_addr <= first_addr;
`ifdef DELAY_TAP_READER_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          w_upd <= DATA_W'(mac_res);
          if (mem.mem_ready) begin
            rdata  <= mem.mem_rdata;
            rd_req <= 1'b0;
            state  <= ST_MAC;
          end
`ifdef DELAY_TAP_READER_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up on this tap: it contributes silence
            rdata   <= '0;
            rd_req  <= 1'b0;
            mem_err <= 1'b1;
            state   <= ST_MAC;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_MAC: begin
          acc <= mac_res;
          w   <= w_upd;
          k   <= k + 1'b1;
          if (k == n_taps - 1'b1) begin
            state <= ST_OUT;
          end else begin
            state   <= ST_REQ;
            rd_req  <= 1'b1;
            rd_addr <= rd_addr - delay_s;
`ifdef DELAY_TAP_READER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_OUT: begin
          data_out   <= DATA_W'(sat16(32'(acc)));
          data_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef DELAY_TAP_READER_TIMEOUT_EN
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: directed and random samples checked against a
// plain-arithmetic model of the multi-tap echo (gain^k weighting, saturation).
module tb_delay_tap_reader;
  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_clock = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] delay_reverb = '0;
  logic [15:0] gain = '0;
  logic [15:0] impulses = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        overrun;
  logic        mem_err;

  delay_tap_reader_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  delay_tap_reader #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MAX_TAPS (8)
`ifdef DELAY_TAP_READER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_CYC)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_clock    (adc_clock),
    .enable       (enable),
    .wr_addr      (wr_addr),
    .delay_reverb (delay_reverb),
    .gain         (gain),
    .impulses     (impulses),
    .data_in      (data_in),
    .mem          (mem_if),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .overrun      (overrun),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mem_arr [65536];
  int          cur_waits = 0;
  int          wait_cnt = 0;
  bit          prev_re = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] first_req_addr = '0;
  int          req_count = 0;
  bit          exp_overrun = 1'b0;
  bit          exp_mem_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory slave: answers each request after cur_waits idle cycles
  always @(negedge clk) begin
    if (mem_if.mem_re) begin
      if (prev_re) begin
        check("addr_stable", mem_if.mem_addr, prev_addr);
      end else begin
        if (req_count == 0) first_req_addr = mem_if.mem_addr;
        req_count++;
      end
      if (wait_cnt >= cur_waits) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = mem_arr[mem_if.mem_addr];
      end else begin
        mem_if.mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_if.mem_ready = 1'b0;
      wait_cnt = 0;
    end
    prev_re   = mem_if.mem_re;
    prev_addr = mem_if.mem_addr;
  end

  task automatic run_sample(input string name, input bit en, input logic [15:0] din,
                            input logic [15:0] wa, input logic [15:0] dly,
                            input logic [15:0] g, input logic [15:0] imp,
                            input int waits, input bit poke);
    int          n, req_len, exp_lat, acc, w, p, t0, t1;
    shortint     s;
    logic [15:0] a, exp_out;
    bit          timed_out, got;
    n = (imp > 16'd8) ? 8 : int'(imp);
    if (!en) n = 0;
    timed_out = 1'b0;
`ifdef DELAY_TAP_READER_TIMEOUT_EN
    if (waits >= TO_CYC) timed_out = 1'b1;
`endif
    req_len = timed_out ? TO_CYC : waits + 1;
    acc = int'(shortint'(din));
    w   = int'(shortint'(g));
    a   = wa;
    for (int i = 0; i < n; i++) begin
      a   = a - dly;
      s   = timed_out ? shortint'(0) : shortint'(mem_arr[a]);
      acc = acc + ((int'(s) * w) >>> 15);
      p   = (w * int'(shortint'(g))) >>> 15;
      w   = int'(shortint'(p));
    end
    if (acc > 32767) exp_out = 16'h7FFF;
    else if (acc < -32768) exp_out = 16'h8000;
    else exp_out = acc[15:0];
    exp_lat = (n == 0) ? 1 : 1 + n * (req_len + 1);
    if (timed_out && n > 0) exp_mem_err = 1'b1;

    @(negedge clk);
    enable = en; data_in = din; wr_addr = wa; delay_reverb = dly; gain = g; impulses = imp;
    cur_waits = waits; req_count = 0; adc_clock = 1'b1;
    t0 = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) begin t0 = cyc; break; end
    end
    if (t0 < 0) begin
      check({name, "_start"}, 32'd0, 32'd1);
      adc_clock = 1'b0;
      return;
    end
    got = 1'b0; t1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (data_valid) begin got = 1'b1; t1 = cyc; break; end
      if (poke && i == 2) adc_clock = 1'b0;
      if (poke && i == 6) begin adc_clock = 1'b1; data_in = ~din; exp_overrun = 1'b1; end
      @(negedge clk);
    end
    check({name, "_done"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_data"}, 32'(data_out), 32'(exp_out));
      check({name, "_lat"}, t1 - t0, exp_lat);
      check({name, "_reads"}, req_count, n);
      if (name == "onetap") check({name, "_addr"}, 32'(first_req_addr), 32'h0000FFF0);
      @(negedge clk);
      check({name, "_pulse"}, 32'(data_valid), 32'd0);
    end
    adc_clock = 1'b0;
    repeat (6) @(negedge clk);
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_ovr"}, 32'(overrun), 32'(exp_overrun));
    check({name, "_err"}, 32'(mem_err), 32'(exp_mem_err));
    $display("txn %-9s en=%0d N=%0d din=%h wa=%h dly=%h g=%h waits=%0d out=%h exp=%h lat=%0d",
             name, en, n, din, wa, dly, g, waits, data_out, exp_out, t1 - t0);
  endtask

  initial begin
    bit          seen;
    logic [15:0] g, old_out;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'($urandom);
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;

    #12;
    check("rst_mem_re", 32'(mem_if.mem_re), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_sample("bypass", 1'b0, 16'h1234, 16'h0100, 16'h0010, 16'h4000, 16'd3, 0, 1'b0);
    mem_arr[16'hFFF0] = 16'h2000;
    run_sample("onetap", 1'b1, 16'h1000, 16'h0010, 16'h0020, 16'h4000, 16'd1, 0, 1'b0);
    mem_arr[16'h0F00] = 16'h7FFF; mem_arr[16'h0E00] = 16'h7FFF; mem_arr[16'h0D00] = 16'h7FFF;
    run_sample("sat_pos", 1'b1, 16'h7FFF, 16'h1000, 16'h0100, 16'h7FFF, 16'd3, 0, 1'b0);
    mem_arr[16'h0F00] = 16'h8000; mem_arr[16'h0E00] = 16'h8000; mem_arr[16'h0D00] = 16'h8000;
    run_sample("sat_neg", 1'b1, 16'h8000, 16'h1000, 16'h0100, 16'h7FFF, 16'd3, 0, 1'b0);
    run_sample("waits", 1'b1, 16'h0321, 16'h4000, 16'h0040, 16'h6000, 16'd2, 5, 1'b0);
    run_sample("dly_zero", 1'b1, 16'hF000, 16'h2222, 16'h0000, 16'h5000, 16'd4, 1, 1'b0);
    run_sample("clamp", 1'b1, 16'h0100, 16'h8000, 16'h0033, 16'hA000, 16'd12, 0, 1'b0);
    run_sample("imp_zero", 1'b1, 16'h5555, 16'h0000, 16'h0010, 16'h4000, 16'd0, 0, 1'b0);
    run_sample("overrun", 1'b1, 16'h0777, 16'h3000, 16'h0100, 16'h3000, 16'd2, 5, 1'b1);

    // Asynchronous reset while a read is outstanding
    old_out = data_out;
    @(negedge clk);
    enable = 1'b1; impulses = 16'd2; cur_waits = 50; adc_clock = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_if.mem_re) begin seen = 1'b1; break; end
    end
    check("rstmid_req", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_mem_re", 32'(mem_if.mem_re), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_data_out", 32'(data_out), 32'd0);
    check("rstmid_valid", 32'(data_valid), 32'd0);
    check("rstmid_overrun", 32'(overrun), 32'd0);
    check("rstmid_mem_err", 32'(mem_err), 32'd0);
    adc_clock = 1'b0; cur_waits = 0; exp_overrun = 1'b0; exp_mem_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("txn reset    data_out before=%h after=%h", old_out, data_out);

    for (int r = 0; r < 40; r++) begin
      g = 16'($urandom);
      if (g == 16'h8000) g = 16'h7FFF;
      run_sample("random", ($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom), g,
                 16'($urandom_range(0, 11)), int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef DELAY_TAP_READER_TIMEOUT_EN
    run_sample("timeout1", 1'b1, 16'h0456, 16'h2000, 16'h0010, 16'h6000, 16'd1, 1000, 1'b0);
    run_sample("timeout2", 1'b1, 16'hF456, 16'h2100, 16'h0020, 16'h4000, 16'd2, 1000, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
